chord_sequencer: RTL and testbench
==================================

# chord_sequencer

Note-issuing front end for the three-voice chord engine. It walks a song stored in an external synchronous ROM and presents each note and duration with a one-cycle `new_note` strobe, but only when the downstream dispatcher reports a free voice on `player_available`. Consecutive note entries issue back-to-back to form chords. Advance entries hold the sequencer for a number of 1/48 s beats before the next entry is read. The block sits between the song ROM and the chord dispatcher.

## Interface
- `SONG_AW`, default 5: per-song index width; each song holds 2^SONG_AW entries.
- `HOLDOFF`, default 2: idle cycles after each issue before `player_available` is sampled again; covers the dispatcher's registered load path.
- `clk` in 1: system clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `play_enable` in 1: high = run; low = freeze all state, ignore `beat`.
- `beat` in 1: one-cycle 1/48 s tick.
- `song` in 2: song select; the upper bits of `rom_addr`.
- `player_available` in 1: high when at least one voice can accept a note.
- `rom_data` in 16: ROM word, valid one cycle after `rom_addr`.
- `rom_addr` out 2+SONG_AW: `{song, idx}`.
- `note_to_load` out 6: note code of the most recent issue.
- `duration` out 6: duration, in beats, of the most recent issue.
- `new_note` out 1: one-cycle issue strobe.
- `song_done` out 1: end of song reached.

## Operation
- ROM word encoding:
  - bit 15 = 0: note entry. `note = [14:9]`, `dur = [8:3]`.
  - bit 15 = 1: advance entry. `wait = [8:3]`; `wait == 0` is the end-of-song marker.
  - Bits [2:0] are ignored.
- FSM states: FETCH, ROMWAIT, DECODE, WAITPLAYER, ISSUE, HOLD, WAITBEATS, DONE.
- FETCH: drive `rom_addr = {song, idx}` → ROMWAIT (1 cycle) → DECODE. DECODE latches `rom_data`.
- Note entry: DECODE → WAITPLAYER.
  - WAITPLAYER → ISSUE when `player_available & play_enable`.
  - ISSUE: register the note onto `note_to_load`/`duration` and pulse `new_note` for one cycle.
  - HOLD: wait HOLDOFF cycles, then `idx <= idx + 1` and go to FETCH.
- Advance entry, `wait != 0`: load the beat counter with `wait` and enter WAITBEATS.
  - Each `beat` seen while `play_enable` is high decrements the counter.
  - When the counter reaches 0: `idx + 1` → FETCH.
- End marker, or `idx` wrapping from 2^SONG_AW-1 to 0 after an increment → DONE.
- DONE: `song_done = 1`, no ROM fetches, no issues.
- Song change: any cycle in which `song` differs from its registered copy sets `idx = 0`, clears the beat counter and `song_done`, and goes to FETCH. This takes priority over every other transition, including an ISSUE in the same cycle, which is suppressed.
- `play_enable` low: the FSM, counters and HOLD count all stall. Outputs hold their values. `new_note` stays 0.
- Note entries with `dur == 0` issue normally; the dispatcher defines what that means.

## Timing
- Reset values: `rom_addr = 0`, `note_to_load = 0`, `duration = 0`, `new_note = 0`, `song_done = 0`, state FETCH, `idx = 0`.
- On release of `reset`, the first FETCH occurs on the first rising edge.
- Minimum entry-to-entry spacing for back-to-back notes with `player_available` held high: FETCH + ROMWAIT + DECODE + WAITPLAYER + ISSUE + HOLDOFF = 5 + HOLDOFF cycles (7 at default). Successive `new_note` pulses are therefore 7 cycles apart.
- `note_to_load` and `duration` change only in the ISSUE cycle and stay stable until the next issue.
- `player_available` is sampled only in WAITPLAYER. If it drops in that same cycle, no issue occurs.
- `beat` coinciding with the DECODE of an advance entry is not counted. Counting starts in WAITBEATS.
- `reset` asserted mid-operation forces all outputs to their reset values immediately, including any `new_note` in flight, regardless of `clk`.

## Configuration
- Macro: `CHORD_SEQ_LOOP_EN`.
- Defined: on the end marker or index wrap, the sequencer pulses `song_done` for exactly one cycle, sets `idx = 0` and returns to FETCH, so the song loops indefinitely.
- Undefined: the sequencer enters DONE and holds `song_done` high until `reset` or a song change.

## Test plan
- Chord issue: song 0 = {note 0x20 dur 12, note 0x24 dur 12, note 0x27 dur 12, end}, `player_available = 1` → three `new_note` pulses 7 cycles apart carrying 0x20/0x24/0x27 with duration 12, then `song_done = 1` (loop off).
- Backpressure: `player_available` held 0 for 50 cycles in WAITPLAYER → no `new_note`. The pulse occurs in the cycle after `player_available` rises, i.e. WAITPLAYER→ISSUE.
- Advance: entry {advance wait 3} followed by a note → exactly 3 `beat` pulses elapse before the next FETCH. Beats delivered with `play_enable = 0` are not counted.
- Song switch: change `song` 0→2 while in WAITBEATS → `rom_addr` becomes `{2, 0}` and `song_done = 0`. No stale note is issued.
- Reset mid-song: assert `reset` low during ISSUE → `new_note`, `note_to_load` and `duration` read 0 before the next clock edge. After release, fetch restarts at `{song, 0}`.
- Loop build: with `CHORD_SEQ_LOOP_EN` defined, reaching the end marker gives a one-cycle `song_done` pulse, followed by re-issue of the first note.

Source files
------------

// File: rtl/chord_sequencer_if.sv
// chord_sequencer_if: song ROM port plus note-issue port of the chord sequencer.
// master = the sequencer, slave = the ROM / dispatcher / transport side.
interface chord_sequencer_if #(
   parameter int SONG_AW = 5
);
   logic                 play_enable;
   logic                 beat;
   logic [1:0]           song;
   logic                 player_available;
   logic [15:0]          rom_data;
   logic [SONG_AW+1:0]   rom_addr;
   logic [5:0]           note_to_load;
   logic [5:0]           duration;
   logic                 new_note;
   logic                 song_done;

   modport master (
      input  play_enable, beat, song, player_available, rom_data,
      output rom_addr, note_to_load, duration, new_note, song_done
   );

   modport slave (
      output play_enable, beat, song, player_available, rom_data,
      input  rom_addr, note_to_load, duration, new_note, song_done
   );
endinterface

// File: rtl/chord_sequencer.sv
// chord_sequencer: walks a song in a synchronous ROM and issues notes to the
// chord dispatcher whenever a voice is free; advance entries wait for beats.
// Optional build macro CHORD_SEQ_LOOP_EN: at the end of a song, pulse
// song_done for one cycle and restart from entry 0 instead of stopping.
module chord_sequencer #(
   parameter int SONG_AW = 5,
   parameter int HOLDOFF = 2
) (
   input  logic              clk,
   input  logic              reset,
   chord_sequencer_if.master bus
);

   localparam int HW = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;

   typedef enum logic [2:0] {
      S_FETCH,
      S_ROMWAIT,
      S_DECODE,
      S_WAITPLAYER,
      S_ISSUE,
      S_HOLD,
      S_WAITBEATS,
      S_DONE
   } state_t;

   state_t             state;
   logic [SONG_AW-1:0] idx;
   logic [SONG_AW-1:0] idx_inc;
   logic [1:0]         song_q;
   logic [5:0]         beat_cnt;
   logic [HW-1:0]      hold_cnt;
   logic [5:0]         note_q;
   logic [5:0]         dur_q;

   logic               song_change;
   logic               end_marker;
   logic               entry_done;
   logic               song_end;
   logic               unused_rom_bits;

   assign idx_inc         = idx + SONG_AW'(1);
   assign song_change     = (bus.song != song_q);
   assign end_marker      = (state == S_DECODE) && bus.rom_data[15] && (bus.rom_data[8:3] == 6'd0);
   assign song_end        = end_marker || (entry_done && (idx == '1));
   assign unused_rom_bits = ^bus.rom_data[2:0];

   // Flag the cycle in which the current entry has finished and idx should move on.
   always_comb begin
      // NOTE: assign a default before the case so no path leaves entry_done unassigned (no latch).
      entry_done = 1'b0;
      case (state)
         S_ISSUE:     entry_done = (HOLDOFF == 0);
         S_HOLD:      entry_done = (hold_cnt == '0);
         S_WAITBEATS: entry_done = bus.beat && (beat_cnt == 6'd1);
         default:     entry_done = 1'b0;
      endcase
   end

   // Sequencer FSM with registered ROM address and note outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state             <= S_FETCH;
         idx               <= '0;
         song_q            <= '0;
         beat_cnt          <= '0;
         hold_cnt          <= '0;
         note_q            <= '0;
         dur_q             <= '0;
         bus.rom_addr      <= '0;
         bus.note_to_load  <= '0;
         bus.duration      <= '0;
         bus.new_note      <= 1'b0;
         bus.song_done     <= 1'b0;
      end else begin
         // NOTE: non-blocking everywhere here; new_note defaults low so it can only ever be a one-cycle strobe.
         bus.new_note <= 1'b0;
`ifdef CHORD_SEQ_LOOP_EN
         bus.song_done <= 1'b0;
`endif
         if (song_change) begin
            // A new song wins over everything, including an issue decided this cycle.
            song_q        <= bus.song;
            idx           <= '0;
            beat_cnt      <= '0;
            hold_cnt      <= '0;
            bus.song_done <= 1'b0;
            bus.rom_addr  <= {bus.song, {SONG_AW{1'b0}}};
            state         <= S_FETCH;
         end else if (bus.play_enable) begin
            if (song_end) begin
               bus.song_done <= 1'b1;
`ifdef CHORD_SEQ_LOOP_EN
               idx          <= '0;
               bus.rom_addr <= {song_q, {SONG_AW{1'b0}}};
               state        <= S_FETCH;
`else
               state        <= S_DONE;
`endif
            end else if (entry_done) begin
               idx          <= idx_inc;
               bus.rom_addr <= {song_q, idx_inc};
               state        <= S_FETCH;
            end else begin
               case (state)
                  S_FETCH:   state <= S_ROMWAIT;
                  S_ROMWAIT: state <= S_DECODE;
                  S_DECODE: begin
                     if (!bus.rom_data[15]) begin
                        note_q <= bus.rom_data[14:9];
                        dur_q  <= bus.rom_data[8:3];
                        state  <= S_WAITPLAYER;
                     end else begin
                        // Zero wait is the end marker and is handled by song_end.
                        beat_cnt <= bus.rom_data[8:3];
                        state    <= S_WAITBEATS;
                     end
                  end
                  S_WAITPLAYER: begin
                     if (bus.player_available) begin
                        bus.new_note     <= 1'b1;
                        bus.note_to_load <= note_q;
                        bus.duration     <= dur_q;
                        state            <= S_ISSUE;
                     end
                  end
                  S_ISSUE: begin
                     hold_cnt <= HW'(HOLDOFF - 1);
                     state    <= S_HOLD;
                  end
                  S_HOLD:      hold_cnt <= hold_cnt - HW'(1);
                  S_WAITBEATS: if (bus.beat) beat_cnt <= beat_cnt - 6'd1;
                  S_DONE:      state <= S_DONE;
                  default:     state <= S_FETCH;
               endcase
            end
         end
      end
   end

endmodule

// File: tb/tb_chord_sequencer.sv
// tb_chord_sequencer: directed scenarios plus randomized run, every cycle
// compared against an entry/age based reference model of the sequencer.
module tb_chord_sequencer;

   localparam int SONG_AW = 5;
   localparam int HOLDOFF = 2;
   localparam int NE      = 1 << SONG_AW;

   logic clk;
   logic reset;
   int   total;
   int   bad;

   chord_sequencer_if #(.SONG_AW(SONG_AW)) bus ();

   chord_sequencer #(.SONG_AW(SONG_AW), .HOLDOFF(HOLDOFF)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   logic [15:0] rom [0:4*NE-1];

   // Clock generation.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Synchronous song ROM: data valid the cycle after the address.
   always @(posedge clk) bus.rom_data <= rom[bus.rom_addr];

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [15:0] note_w(input logic [5:0] n, input logic [5:0] d, input logic [2:0] junk);
      return {1'b0, n, d, junk};
   endfunction

   function automatic logic [15:0] adv_w(input logic [5:0] w, input logic [5:0] junk_hi, input logic [2:0] junk);
      return {1'b1, junk_hi, w, junk};
   endfunction

   // ---------------- reference model ----------------
   // Tracks, per entry, how many enabled cycles have elapsed since its fetch
   // (m_age) and when its note went out; outputs follow from those counts.
   logic [1:0]         m_song;
   int                 m_idx;
   int                 m_age;
   int                 m_issue_age;
   int                 m_beats;
   bit                 m_stuck;
   logic [SONG_AW+1:0] m_addr;
   logic [5:0]         m_note;
   logic [5:0]         m_dur;
   logic               m_new;
   logic               m_done;

   // Reference model advance, one step per rising edge.
   always @(posedge clk or negedge reset) begin
      logic [15:0] word;
      bit          next_entry;
      bit          end_song;
      if (!reset) begin
         m_song = 2'd0; m_idx = 0; m_age = 0; m_issue_age = -1; m_beats = 0; m_stuck = 0;
         m_addr = '0; m_note = '0; m_dur = '0; m_new = 1'b0; m_done = 1'b0;
      end else begin
         m_new = 1'b0;
`ifdef CHORD_SEQ_LOOP_EN
         m_done = 1'b0;
`endif
         if (bus.song != m_song) begin
            m_song = bus.song; m_idx = 0; m_age = 0; m_issue_age = -1; m_beats = 0;
            m_stuck = 0; m_done = 1'b0; m_addr = {bus.song, 5'd0};
         end else if (bus.play_enable && !m_stuck) begin
            word       = rom[{m_song, 5'(m_idx)}];
            next_entry = 0;
            end_song   = 0;
            if (m_age == 2) begin
               if (word[15] && word[8:3] == 6'd0) end_song = 1;
               else if (word[15]) m_beats = int'(word[8:3]);
            end else if (m_age >= 3) begin
               if (word[15]) begin
                  if (bus.beat) begin
                     m_beats--;
                     if (m_beats == 0) next_entry = 1;
                  end
               end else if (m_issue_age < 0) begin
                  if (bus.player_available) begin
                     m_new = 1'b1; m_note = word[14:9]; m_dur = word[8:3];
                     m_issue_age = m_age + 1;
                  end
               end else if (m_age - m_issue_age == HOLDOFF) begin
                  next_entry = 1;
               end
            end
            if (next_entry && m_idx == NE - 1) end_song = 1;
            if (end_song) begin
               m_done = 1'b1;
`ifdef CHORD_SEQ_LOOP_EN
               m_idx = 0; m_age = 0; m_issue_age = -1; m_addr = {m_song, 5'd0};
`else
               m_stuck = 1;
`endif
            end else if (next_entry) begin
               m_idx++; m_age = 0; m_issue_age = -1; m_addr = {m_song, 5'(m_idx)};
            end else begin
               m_age++;
            end
         end
      end
   end

   // Compare all DUT outputs against the model on every falling edge out of reset.
   always @(negedge clk) begin
      if (reset === 1'b1) begin
         check("rom_addr",     32'(bus.rom_addr),     32'(m_addr));
         check("note_to_load", 32'(bus.note_to_load), 32'(m_note));
         check("duration",     32'(bus.duration),     32'(m_dur));
         check("new_note",     32'(bus.new_note),     32'(m_new));
         check("song_done",    32'(bus.song_done),    32'(m_done));
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic do_reset(input logic [1:0] s, input logic pa);
      @(negedge clk);
      reset = 1'b0;
      bus.song = s; bus.player_available = pa; bus.play_enable = 1'b1; bus.beat = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("reset rom_addr",  32'(bus.rom_addr), 0);
      check("reset note",      32'(bus.note_to_load), 0);
      check("reset duration",  32'(bus.duration), 0);
      check("reset new_note",  32'(bus.new_note), 0);
      check("reset song_done", 32'(bus.song_done), 0);
      reset = 1'b1;
   endtask

   task automatic wait_note(input string tag);
      int n = 0;
      while (bus.new_note !== 1'b1 && n < 60) begin
         @(negedge clk);
         n++;
      end
      check(tag, 32'(bus.new_note), 1);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      int         pulse_at [$];
      logic [5:0] pulse_note [$];
      logic [5:0] pulse_dur [$];
      logic [5:0] chord_notes [3];
      int         first_done;
      int         done_cycles;
      int         quiet;
      int         issues;

      total = 0; bad = 0;
      reset = 1'b0;
      bus.song = 2'd0; bus.play_enable = 1'b1; bus.beat = 1'b0; bus.player_available = 1'b1;

      for (int i = 0; i < 4*NE; i++) rom[i] = note_w(6'h3f, 6'h3f, 3'd0);
      // song 0: three-note chord then end marker
      rom[0] = note_w(6'h20, 6'd12, 3'd0);
      rom[1] = note_w(6'h24, 6'd12, 3'd5);
      rom[2] = note_w(6'h27, 6'd12, 3'd0);
      rom[3] = adv_w(6'd0, 6'h2a, 3'd7);
      // song 1: wait 3 beats, one note, end
      rom[NE+0] = adv_w(6'd3, 6'h15, 3'd2);
      rom[NE+1] = note_w(6'h11, 6'd5, 3'd0);
      rom[NE+2] = adv_w(6'd0, 6'd0, 3'd0);
      // songs 2 and 3: random entries; song 2 has no end marker so it wraps
      for (int s = 2; s < 4; s++) begin
         for (int i = 0; i < NE; i++) begin
            if ($urandom_range(3) == 0 && !(s == 3 && i == 0))
               rom[s*NE+i] = adv_w(6'($urandom_range(3, 1)), 6'($urandom), 3'($urandom));
            else
               rom[s*NE+i] = note_w(6'($urandom), 6'($urandom_range(63)), 3'($urandom));
         end
      end
      rom[3*NE+10] = adv_w(6'd0, 6'($urandom), 3'($urandom));

      // --- chord issue on song 0 ---
      do_reset(2'd0, 1'b1);
      first_done = -1; done_cycles = 0;
      for (int i = 1; i <= 30; i++) begin
         @(negedge clk);
         if (bus.new_note === 1'b1) begin
            pulse_at.push_back(i);
            pulse_note.push_back(bus.note_to_load);
            pulse_dur.push_back(bus.duration);
         end
         if (bus.song_done === 1'b1) begin
            done_cycles++;
            if (first_done < 0) first_done = i;
         end
         if (i == 4) check("model pinned note", 32'(m_note), 32'h20);
      end
      chord_notes = '{6'h20, 6'h24, 6'h27};
`ifdef CHORD_SEQ_LOOP_EN
      check("chord pulse count", pulse_at.size(), 4);
      check("done pulse width", done_cycles, 1);
      if (pulse_at.size() >= 4) begin
         check("loop reissue time", pulse_at[3], 28);
         check("loop reissue note", 32'(pulse_note[3]), 32'h20);
      end
`else
      check("chord pulse count", pulse_at.size(), 3);
      check("done held cycles", done_cycles, 7);
`endif
      check("chord done time", first_done, 24);
      if (pulse_at.size() >= 3) begin
         for (int k = 0; k < 3; k++) begin
            check("chord pulse time", pulse_at[k], 4 + 7*k);
            check("chord note", 32'(pulse_note[k]), 32'(chord_notes[k]));
            check("chord duration", 32'(pulse_dur[k]), 12);
         end
      end

      // --- backpressure ---
      do_reset(2'd0, 1'b0);
      quiet = 0;
      for (int i = 1; i <= 50; i++) begin
         @(negedge clk);
         if (bus.new_note === 1'b1) quiet++;
      end
      check("backpressure quiet", quiet, 0);
      bus.player_available = 1'b1;
      @(negedge clk);
      check("backpressure pulse", 32'(bus.new_note), 1);
      check("backpressure note", 32'(bus.note_to_load), 32'h20);

      // --- advance: DECODE beat ignored, disabled beat ignored, 3 counted ---
      do_reset(2'd1, 1'b1);
      for (int i = 1; i <= 13; i++) begin
         @(negedge clk);
         if (i == 11) check("advance after 2 beats", 32'(bus.rom_addr), 32'h20);
         if (i == 12) check("advance before 3rd beat", 32'(bus.rom_addr), 32'h20);
         if (i == 13) check("advance fetch next", 32'(bus.rom_addr), 32'h21);
         bus.beat        = (i == 3 || i == 6 || i == 8 || i == 10 || i == 12);
         bus.play_enable = (i != 8);
      end
      wait_note("advance note issued");
      check("advance note", 32'(bus.note_to_load), 32'h11);
      check("advance duration", 32'(bus.duration), 5);

      // --- song switch while waiting for beats ---
      do_reset(2'd1, 1'b1);
      for (int i = 1; i <= 5; i++) @(negedge clk);
      bus.song = 2'd2;
      @(negedge clk);
      check("switch rom_addr", 32'(bus.rom_addr), 32'h40);
      check("switch song_done", 32'(bus.song_done), 0);
      check("switch no stale note", 32'(bus.new_note), 0);

      // --- randomized run ---
      issues = 0;
      for (int i = 0; i < 4000; i++) begin
         @(negedge clk);
         if (bus.new_note === 1'b1) issues++;
         bus.play_enable      = ($urandom_range(7) != 0);
         bus.player_available = ($urandom_range(3) != 0);
         bus.beat             = ($urandom_range(2) == 0);
         if ($urandom_range(199) == 0) bus.song = 2'($urandom_range(3));
      end
      check("random issues seen", int'(issues > 0), 1);
      bus.play_enable = 1'b1; bus.beat = 1'b0; bus.player_available = 1'b1;

      // --- reset during ISSUE ---
      do_reset(2'd3, 1'b1);
      wait_note("pre-reset note issued");
      #2 reset = 1'b0;
      #1;
      check("async reset new_note", 32'(bus.new_note), 0);
      check("async reset note", 32'(bus.note_to_load), 0);
      check("async reset duration", 32'(bus.duration), 0);
      check("async reset rom_addr", 32'(bus.rom_addr), 0);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check("restart rom_addr", 32'(bus.rom_addr), 32'h60);
      wait_note("restart note issued");
      check("restart note", 32'(bus.note_to_load), 32'(rom[3*NE][14:9]));

      @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
